rst_trig: RTL and testbench
===========================

// Module: rst_trig
// PURPOSE
//  Reset-request source for the system reset generator. Collects reset causes and drives rst_req into rst_in.
//  Causes: debounced push button, watchdog timeout pulse, keyed software write.
//  Holds rst_req for a fixed pulse, then enforces a hold-off.
//  Keeps a sticky cause register and a reset count that survive the resets it requests; CPU reads them via IO.
// PARAMETERS
//  DEBOUNCE_CYCLES  500000  button level must be stable this many clk cycles to be accepted
//  PULSE_CYCLES     16      clk cycles rst_req is held high per trigger (>=1)
//  HOLDOFF_CYCLES   1000    clk cycles after pulse before a new trigger is accepted (>=1)
//  SW_KEY           8'hA5   data_in[7:0] value that arms a software reset
// PORTS
//  clk        in   1   system clock; single clock domain
//  rst        in   1   asynchronous, active-high reset; power-on only, never driven by rst_req's downstream reset
//  btn_in     in   1   raw push button, active-high, asynchronous to clk
//  wd_to      in   1   watchdog timeout, clk-synchronous, >=1-cycle pulse
//  io_en      in   1   IO select for this block
//  rd         in   1   IO read strobe (qualified by io_en)
//  wr         in   1   IO write strobe (qualified by io_en)
//  data_in    in   32  IO write data
//  data_out   out  32  IO read data: [3:0]=cause, [15:8]=count, rest 0; zero when ~(io_en&rd)
//  rst_req    out  1   registered reset request into the reset generator's rst_in
// BEHAVIOUR
//  Reset (rst=1): rst_req=0, cause=0, count=0, FSM=IDLE, debounced button=0, sync flops=0; data_out=0.
//  btn_in: 2-flop synchroniser. Debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
//    btn_ev = one-cycle pulse on debounced 0->1 edge.
//  sw_ev = io_en & wr & data_in[7:0]==SW_KEY.
//  IO write with data_in[8]=1 clears cause and count. A key write that also sets bit 8 clears, then records sw.
//  FSM: IDLE -> PULSE -> HOLD -> IDLE.
//   IDLE: trig = btn_ev|wd_to|sw_ev. On trig:
//     - OR all simultaneous sources into cause: bit0 btn, bit1 wd, bit2 sw, bit3 = 1 if >1 source.
//     - count += 1, saturating at 8'hFF.
//     - load pulse counter; go PULSE. rst_req rises on the clk edge after trig (latency 1).
//   PULSE: rst_req=1 for exactly PULSE_CYCLES cycles. Then rst_req=0, load hold counter, go HOLD.
//   HOLD: count HOLDOFF_CYCLES. Exit to IDLE only when expired AND debounced button=0.
//     A held button therefore causes no retrigger.
//  Triggers in PULSE/HOLD are ignored: no cause update, no count change.
//  Cause bits are sticky; only rst or a clear write zero them. Prior bits stay when a new cause is ORed in.
//  Reads are combinational: data_out valid in the same cycle as io_en&rd. A read has no side effect.
//  Counter widths: $clog2(param+1). All counters count down to 0.
//  rst asserted mid-PULSE: rst_req drops immediately (async) and FSM returns to IDLE.
// STRUCTURE
//  Shared package/header rst_trig_pkg:
//    - cause bit indices CAUSE_BTN=0, CAUSE_WD=1, CAUSE_SW=2, CAUSE_MULTI=3
//    - FSM state encodings IDLE/PULSE/HOLD
//    - IO bit positions: clear bit 8, count field [15:8]
//  One sub-module: btn_debounce (synchroniser + stability counter + edge pulse), parameter DEBOUNCE_CYCLES.
//  FSM, cause/count registers and IO decode stay in rst_trig.
// TESTING (sim params DEBOUNCE_CYCLES=8, PULSE_CYCLES=4, HOLDOFF_CYCLES=6)
//  1. wd_to 1-cycle pulse in IDLE -> rst_req high next cycle for exactly 4 cycles; read gives cause=4'b0010, count=1.
//  2. btn_in high 5 cycles, then low -> no trigger. btn_in held high 20 cycles -> one trigger, cause bit0 set.
//     Still held after HOLD -> FSM stays in HOLD; release -> IDLE; no second pulse.
//  3. Write 0x000000A5 -> rst_req pulse, cause=4'b0100. Write 0x000000A4 -> no pulse.
//  4. wd_to and key write in the same cycle -> single pulse, cause=4'b1110, count +1.
//  5. wd_to during PULSE and during HOLD -> ignored; cause and count unchanged. After HOLD, wd_to -> new pulse, count=2.
//  6. Write 0x100 -> cause=0, count=0. Force 256 triggers -> count saturates at 8'hFF.
//     Assert rst mid-PULSE -> rst_req=0 and all registers 0 at once.

Source files
------------

// File: rtl/rst_trig_pkg.sv
// rst_trig_pkg: shared cause indices, FSM encodings and IO field positions for rst_trig
package rst_trig_pkg;
  localparam int CAUSE_BTN = 0;
  localparam int CAUSE_WD = 1;
  localparam int CAUSE_SW = 2;
  localparam int CAUSE_MULTI = 3;
  localparam int CLR_BIT = 8;
  localparam int CNT_LSB = 8;
  localparam int CNT_MSB = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, HOLD = 2'd2} state_t;
endpackage

// File: rtl/rst_trig_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and rising-edge pulse for the push button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic ev
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2;
  logic [W-1:0] cnt;
  // cnt tracks consecutive samples that disagree with level; any agreeing sample restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      ev <= 1'b0;
      cnt <= W'(DEBOUNCE_CYCLES - 1);
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      ev <= 1'b0;
      if (s2 == level) cnt <= W'(DEBOUNCE_CYCLES - 1);
      else if (cnt == '0) begin
        level <= s2;
        ev <= s2;
        cnt <= W'(DEBOUNCE_CYCLES - 1);
      end else cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/rst_trig.sv
// rst_trig: collects reset causes, drives a fixed-length rst_req pulse with hold-off, keeps sticky cause/count
module rst_trig
  import rst_trig_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PULSE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter logic [7:0] SW_KEY = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_in,
  input  logic        wd_to,
  input  logic        io_en,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rst_req
);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  state_t state, state_d;
  logic [PW-1:0] pcnt, pcnt_d;
  logic [HW-1:0] hcnt, hcnt_d;
  logic [3:0] cause, cause_d, src;
  logic [7:0] count, count_d;
  logic level, btn_ev, sw_ev, clr, rst_req_d;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(level), .ev(btn_ev)
  );
  assign sw_ev = io_en & wr & (data_in[7:0] == SW_KEY);
  assign clr = io_en & wr & data_in[CLR_BIT];
  always_comb begin
    src = '0;
    src[CAUSE_BTN] = btn_ev;
    src[CAUSE_WD] = wd_to;
    src[CAUSE_SW] = sw_ev;
    src[CAUSE_MULTI] = (btn_ev & wd_to) | (btn_ev & sw_ev) | (wd_to & sw_ev);
  end
  // a clear write takes effect first so a combined clear+key write still records its own cause
  always_comb begin
    state_d = state;
    pcnt_d = pcnt;
    hcnt_d = hcnt;
    rst_req_d = rst_req;
    cause_d = clr ? '0 : cause;
    count_d = clr ? '0 : count;
    case (state)
      IDLE: if (|src) begin
        state_d = PULSE;
        pcnt_d = PW'(PULSE_CYCLES - 1);
        rst_req_d = 1'b1;
        cause_d = cause_d | src;
        count_d = (count_d == 8'hFF) ? count_d : count_d + 8'd1;
      end
      PULSE: if (pcnt == '0) begin
        state_d = HOLD;
        hcnt_d = HW'(HOLDOFF_CYCLES - 1);
        rst_req_d = 1'b0;
      end else pcnt_d = pcnt - 1'b1;
      HOLD: if (hcnt != '0) hcnt_d = hcnt - 1'b1;
        else if (!level) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pcnt <= '0;
      hcnt <= '0;
      rst_req <= 1'b0;
      cause <= '0;
      count <= '0;
    end else begin
      state <= state_d;
      pcnt <= pcnt_d;
      hcnt <= hcnt_d;
      rst_req <= rst_req_d;
      cause <= cause_d;
      count <= count_d;
    end
  end
  always_comb begin
    data_out = '0;
    if (io_en & rd) begin
      data_out[3:0] = cause;
      data_out[CNT_MSB:CNT_LSB] = count;
    end
  end
endmodule

// File: tb/tb_rst_trig.sv
// tb_rst_trig: directed scenario tasks for rst_trig with DEBOUNCE=8, PULSE=4, HOLDOFF=6
module tb_rst_trig;
  logic clk = 0, rst = 1, btn_in = 0, wd_to = 0, io_en = 0, rd = 0, wr = 0;
  logic [31:0] data_in = '0, data_out;
  logic rst_req;
  logic [3:0] c;
  logic [7:0] n;
  int h;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  rst_trig #(.DEBOUNCE_CYCLES(8), .PULSE_CYCLES(4), .HOLDOFF_CYCLES(6), .SW_KEY(8'hA5)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .wd_to(wd_to), .io_en(io_en), .rd(rd), .wr(wr),
    .data_in(data_in), .data_out(data_out), .rst_req(rst_req)
  );
  task automatic step(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask
  task automatic rd_reg(output logic [3:0] rc, output logic [7:0] rn);
    io_en = 1; rd = 1; #1;
    rc = data_out[3:0]; rn = data_out[15:8];
    io_en = 0; rd = 0;
  endtask
  task automatic fire(input logic w, input logic do_wr, input logic [31:0] d);
    wd_to = w; io_en = do_wr; wr = do_wr; data_in = d;
    step(1);
    wd_to = 0; io_en = 0; wr = 0; data_in = '0;
  endtask
  task automatic count_hi(input int k, output int hh);
    hh = 0;
    repeat (k) begin if (rst_req) hh++; step(1); end
  endtask
  task automatic test_reset;
    step(2);
    io_en = 1; rd = 1; #1;
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL reset_read got %h exp %h", data_out, 32'h0); end
    tests++; if (rst_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", rst_req); end
    io_en = 0; rd = 0;
    rst = 0; step(1);
    rd_reg(c, n);
    tests++; if ({c, n} !== 12'h0) begin fails++; $display("FAIL post_reset got c=%b n=%h exp 0", c, n); end
  endtask
  task automatic test_wd;
    wd_to = 1; #1;
    tests++; if (rst_req !== 1'b0) begin fails++; $display("FAIL wd_latency got %b exp 0", rst_req); end
    step(1); wd_to = 0;
    tests++; if (rst_req !== 1'b1) begin fails++; $display("FAIL wd_rise got %b exp 1", rst_req); end
    count_hi(20, h);
    tests++; if (h != 4) begin fails++; $display("FAIL wd_width got %0d exp 4", h); end
    rd_reg(c, n);
    tests++; if (c !== 4'b0010 || n !== 8'd1) begin fails++; $display("FAIL wd_read got c=%b n=%h exp c=0010 n=01", c, n); end
  endtask
  task automatic test_btn;
    fire(0, 1, 32'h100);
    btn_in = 1; step(5); btn_in = 0;
    count_hi(20, h);
    tests++; if (h != 0) begin fails++; $display("FAIL btn_short got %0d exp 0", h); end
    btn_in = 1;
    count_hi(30, h);
    tests++; if (h != 4) begin fails++; $display("FAIL btn_held got %0d exp 4", h); end
    rd_reg(c, n);
    tests++; if (c !== 4'b0001 || n !== 8'd1) begin fails++; $display("FAIL btn_read got c=%b n=%h exp c=0001 n=01", c, n); end
    fire(1, 0, '0);
    count_hi(10, h);
    tests++; if (h != 0) begin fails++; $display("FAIL btn_hold_wd got %0d exp 0", h); end
    rd_reg(c, n);
    tests++; if (c !== 4'b0001 || n !== 8'd1) begin fails++; $display("FAIL btn_hold_read got c=%b n=%h exp c=0001 n=01", c, n); end
    btn_in = 0;
    count_hi(20, h);
    tests++; if (h != 0) begin fails++; $display("FAIL btn_release got %0d exp 0", h); end
    fire(1, 0, '0);
    tests++; if (rst_req !== 1'b1) begin fails++; $display("FAIL btn_idle_again got %b exp 1", rst_req); end
    step(14);
  endtask
  task automatic test_sw;
    fire(0, 1, 32'h100);
    fire(0, 1, 32'hA5);
    tests++; if (rst_req !== 1'b1) begin fails++; $display("FAIL sw_rise got %b exp 1", rst_req); end
    step(14);
    rd_reg(c, n);
    tests++; if (c !== 4'b0100 || n !== 8'd1) begin fails++; $display("FAIL sw_read got c=%b n=%h exp c=0100 n=01", c, n); end
    fire(0, 1, 32'hA4);
    count_hi(15, h);
    tests++; if (h != 0) begin fails++; $display("FAIL sw_badkey got %0d exp 0", h); end
    fire(1, 0, '0); step(14);
    fire(0, 1, 32'h1A5); step(14);
    rd_reg(c, n);
    tests++; if (c !== 4'b0100 || n !== 8'd1) begin fails++; $display("FAIL sw_clr_key got c=%b n=%h exp c=0100 n=01", c, n); end
  endtask
  task automatic test_simul;
    fire(0, 1, 32'h100);
    fire(1, 0, '0); step(14);
    fire(1, 1, 32'hA5);
    tests++; if (rst_req !== 1'b1) begin fails++; $display("FAIL simul_rise got %b exp 1", rst_req); end
    count_hi(20, h);
    tests++; if (h != 4) begin fails++; $display("FAIL simul_width got %0d exp 4", h); end
    rd_reg(c, n);
    tests++; if (c !== 4'b1110 || n !== 8'd2) begin fails++; $display("FAIL simul_read got c=%b n=%h exp c=1110 n=02", c, n); end
  endtask
  task automatic test_ignore;
    fire(0, 1, 32'h100);
    fire(1, 0, '0); step(1);
    fire(1, 0, '0); step(3);
    fire(1, 0, '0);
    rd_reg(c, n);
    tests++; if (c !== 4'b0010 || n !== 8'd1) begin fails++; $display("FAIL ignore_read got c=%b n=%h exp c=0010 n=01", c, n); end
    step(10);
    fire(1, 0, '0);
    tests++; if (rst_req !== 1'b1) begin fails++; $display("FAIL ignore_retrig got %b exp 1", rst_req); end
    step(14);
    rd_reg(c, n);
    tests++; if (n !== 8'd2) begin fails++; $display("FAIL ignore_count got %h exp 02", n); end
  endtask
  task automatic test_sat_rst;
    fire(0, 1, 32'h100);
    rd_reg(c, n);
    tests++; if ({c, n} !== 12'h0) begin fails++; $display("FAIL clear got c=%b n=%h exp 0", c, n); end
    repeat (255) begin fire(1, 0, '0); step(12); end
    rd_reg(c, n);
    tests++; if (n !== 8'hFF) begin fails++; $display("FAIL count_255 got %h exp ff", n); end
    fire(1, 0, '0); step(12);
    rd_reg(c, n);
    tests++; if (n !== 8'hFF) begin fails++; $display("FAIL count_sat got %h exp ff", n); end
    fire(1, 0, '0); step(1);
    tests++; if (rst_req !== 1'b1) begin fails++; $display("FAIL mid_pulse got %b exp 1", rst_req); end
    #2 rst = 1; #1;
    tests++; if (rst_req !== 1'b0) begin fails++; $display("FAIL async_rst got %b exp 0", rst_req); end
    io_en = 1; rd = 1; #1;
    tests++; if (data_out !== 32'h0) begin fails++; $display("FAIL async_rst_read got %h exp 0", data_out); end
    io_en = 0; rd = 0;
    step(1); rst = 0; step(1);
    tests++; if (rst_req !== 1'b0) begin fails++; $display("FAIL after_rst_idle got %b exp 0", rst_req); end
    fire(1, 0, '0);
    tests++; if (rst_req !== 1'b1) begin fails++; $display("FAIL after_rst_trig got %b exp 1", rst_req); end
    step(14);
    rd_reg(c, n);
    tests++; if (c !== 4'b0010 || n !== 8'd1) begin fails++; $display("FAIL after_rst_read got c=%b n=%h exp c=0010 n=01", c, n); end
  endtask
  initial begin
    test_reset;
    test_wd;
    test_btn;
    test_sw;
    test_simul;
    test_ignore;
    test_sat_rst;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
